// File: rtl/srwpl_seq_ctrl.sv
// srwpl_seq_ctrl: command sequencer for a universal shift register
// (hold / load / shift-left / shift-right).
// Optional build macro SRWPL_ROTATE_EN adds cmd_rot and sr_q ports so a
// shift can recirculate the register's own end bit instead of cmd_fill.
module srwpl_seq_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AMT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [AMT_W-1:0] cmd_amt,
    input  logic             cmd_fill,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             abort,
`ifdef SRWPL_ROTATE_EN
    input  logic             cmd_rot,
    input  logic [WIDTH-1:0] sr_q,
`endif
    output logic [1:0]       sr_sel,
    output logic             sr_il,
    output logic             sr_ir,
    output logic [WIDTH-1:0] sr_d,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [AMT_W-1:0] remaining
);

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_SHR  = 2'b11;

    localparam logic [AMT_W-1:0] AMT_LIMIT = AMT_W'(WIDTH);
    localparam logic [AMT_W-1:0] AMT_ONE   = AMT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state, state_nx;
    logic [1:0]       op_q, op_nx;
    logic             fill_q, fill_nx;
    logic             il_q, il_nx;
    logic             ir_q, ir_nx;
    logic [1:0]       sel_nx;
    logic [WIDTH-1:0] d_nx;
    logic             busy_nx, done_nx, aborted_nx;
    logic [AMT_W-1:0] rem_nx;
    logic [AMT_W-1:0] amt_eff;

    assign cmd_ready = (state == IDLE);
    assign amt_eff   = (cmd_amt > AMT_LIMIT) ? AMT_LIMIT : cmd_amt;

`ifdef SRWPL_ROTATE_EN
    logic rot_q, rot_nx;

    // Rotate mode feeds the live register end bit straight back in.
    always_comb begin
        sr_ir = ir_q;
        sr_il = il_q;
        if (rot_q && (sr_sel == OP_SHL)) sr_ir = sr_q[WIDTH-1];
        if (rot_q && (sr_sel == OP_SHR)) sr_il = sr_q[0];
    end
`else
    assign sr_ir = ir_q;
    assign sr_il = il_q;
`endif

    // Next-state and next-output decode; all outputs are registered below.
    always_comb begin
        state_nx   = state;
        op_nx      = op_q;
        fill_nx    = fill_q;
        sel_nx     = 2'b00;
        il_nx      = 1'b0;
        ir_nx      = 1'b0;
        d_nx       = sr_d;
        done_nx    = 1'b0;
        aborted_nx = 1'b0;
        rem_nx     = '0;
`ifdef SRWPL_ROTATE_EN
        rot_nx     = rot_q;
`endif
        unique case (state)
            IDLE: begin
                if (cmd_valid) begin
                    op_nx   = cmd_op;
                    fill_nx = cmd_fill;
`ifdef SRWPL_ROTATE_EN
                    rot_nx  = cmd_rot;
`endif
                    if (cmd_op == OP_LOAD) begin
                        state_nx = EXEC;
                        sel_nx   = OP_LOAD;
                        d_nx     = cmd_data;
                    end else if (cmd_op != OP_NOP && amt_eff != '0) begin
                        state_nx = EXEC;
                        sel_nx   = cmd_op;
                        rem_nx   = amt_eff;
                        ir_nx    = (cmd_op == OP_SHL) & cmd_fill;
                        il_nx    = (cmd_op == OP_SHR) & cmd_fill;
                    end else begin
                        state_nx = DONE;
                        done_nx  = 1'b1;
                    end
                end
            end
            EXEC: begin
                // remaining holds the cycle count including the current one,
                // so a LOAD (remaining 0) and the last shift both end here.
                if (abort) begin
                    state_nx   = IDLE;
                    aborted_nx = 1'b1;
                end else if (remaining > AMT_ONE) begin
                    sel_nx = op_q;
                    rem_nx = remaining - AMT_ONE;
                    ir_nx  = (op_q == OP_SHL) & fill_q;
                    il_nx  = (op_q == OP_SHR) & fill_q;
                end else begin
                    state_nx = DONE;
                    done_nx  = 1'b1;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        busy_nx = (state_nx != IDLE);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Registered outputs and latched command fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= 2'b00;
            fill_q    <= 1'b0;
            sr_sel    <= 2'b00;
            il_q      <= 1'b0;
            ir_q      <= 1'b0;
            sr_d      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            remaining <= '0;
`ifdef SRWPL_ROTATE_EN
            rot_q     <= 1'b0;
`endif
        end else begin
            op_q      <= op_nx;
            fill_q    <= fill_nx;
            sr_sel    <= sel_nx;
            il_q      <= il_nx;
            ir_q      <= ir_nx;
            sr_d      <= d_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            aborted   <= aborted_nx;
            remaining <= rem_nx;
`ifdef SRWPL_ROTATE_EN
            rot_q     <= rot_nx;
`endif
        end
    end

endmodule

// File: tb/tb_srwpl_seq_ctrl.sv
// Scoreboard bench for srwpl_seq_ctrl with a behavioural shift-register
// environment. Define SRWPL_ROTATE_EN for the rotate build.
module tb_srwpl_seq_ctrl;

    localparam logic [1:0] NOP  = 2'b00;
    localparam logic [1:0] LOAD = 2'b01;
    localparam logic [1:0] SHL  = 2'b10;
    localparam logic [1:0] SHR  = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [5:0]  cmd_amt = '0;
    logic        cmd_fill = 1'b0;
    logic [31:0] cmd_data = '0;
    logic        abort = 1'b0;
    logic        cmd_rot = 1'b0;
    logic [1:0]  sr_sel;
    logic        sr_il, sr_ir;
    logic [31:0] sr_d;
    logic        busy, done, aborted;
    logic [5:0]  remaining;
    logic [31:0] q = '0;

    int n_checks = 0;
    int n_fail   = 0;

    srwpl_seq_ctrl #(.WIDTH(32), .AMT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_amt(cmd_amt), .cmd_fill(cmd_fill), .cmd_data(cmd_data),
        .abort(abort),
`ifdef SRWPL_ROTATE_EN
        .cmd_rot(cmd_rot), .sr_q(q),
`endif
        .sr_sel(sr_sel), .sr_il(sr_il), .sr_ir(sr_ir), .sr_d(sr_d), .busy(busy),
        .done(done), .aborted(aborted), .remaining(remaining)
    );

    always #5 clk = ~clk;

    // Environment: the universal shift register driven by the controller.
    always @(posedge clk) begin
        case (sr_sel)
            LOAD:    q <= sr_d;
            SHL:     q <= {q[30:0], sr_ir};
            SHR:     q <= {sr_il, q[31:1]};
            default: q <= q;
        endcase
    end

    typedef struct {
        logic [1:0]  op;
        int unsigned n;
        logic        fill;
        logic        rot;
        logic [31:0] data;
        int unsigned active;
        int unsigned end_cyc;
        logic        is_abort;
        logic [31:0] q;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ref_q = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] v, input logic [1:0] op,
                                              input int unsigned k, input logic fill,
                                              input logic rot);
        logic [63:0] w;
        logic [31:0] f;
        f = fill ? '1 : '0;
        if (k == 0) return v;
        if (op == SHL) begin
            w = rot ? ({v, v} << k) : ({v, f} << k);
            return w[63:32];
        end
        w = rot ? ({v, v} >> k) : ({f, v} >> k);
        return w[31:0];
    endfunction

    // amode: 0 none, 1 abort in EXEC cycle k, 4 abort in DONE cycle, 5 abort with cmd_valid
    task automatic issue(input logic [1:0] op, input logic [5:0] amt, input logic fill,
                         input logic [31:0] data, input logic rot, input int unsigned amode_in,
                         input int unsigned k_in);
        exp_t        e;
        int unsigned t = 0;
        int unsigned amode = amode_in;
        int unsigned k = k_in;
        int unsigned c;
`ifndef SRWPL_ROTATE_EN
        rot = 1'b0;
`endif
        while (!cmd_ready && t < 200) begin
            @(posedge clk); #1; t++;
        end
        check("accept_wait", cmd_ready, 1);
        e.op = op; e.fill = fill; e.rot = rot; e.data = data;
        e.n = (amt > 32) ? 32 : amt;
        e.is_abort = 1'b0;
        if (op == LOAD) begin
            e.active = 1; e.end_cyc = 2; e.q = data;
            if (amode == 1) e.is_abort = 1'b1;
        end else if (op != NOP && e.n > 0) begin
            if (amode == 1) begin
                if (k < 1) k = 1;
                if (k > e.n) k = e.n;
                e.is_abort = 1'b1;
                e.active = k; e.end_cyc = k + 1;
                e.q = ref_shift(ref_q, op, k, fill, rot);
            end else begin
                e.active = e.n; e.end_cyc = e.n + 1;
                e.q = ref_shift(ref_q, op, e.n, fill, rot);
            end
        end else begin
            if (amode == 1) amode = 0;
            e.active = 0; e.end_cyc = 1; e.q = ref_q;
        end
        if (op == LOAD && amode == 1) k = 1;
        sb.push_back(e);
        ref_q = e.q;
        cmd_valid = 1'b1; cmd_op = op; cmd_amt = amt; cmd_fill = fill;
        cmd_data = data; cmd_rot = rot; abort = (amode == 5);
        @(posedge clk); #1;
        cmd_valid = 1'b0; abort = 1'b0;
        cmd_op = 2'($urandom); cmd_amt = 6'($urandom); cmd_fill = 1'($urandom);
        cmd_data = $urandom; cmd_rot = 1'($urandom);
        if (amode == 1 || amode == 4) begin
            c = (amode == 1) ? k : e.end_cyc;
            repeat (c - 1) begin @(posedge clk); #1; end
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int unsigned t = 0;
        while (!cmd_ready && t < 200) begin
            @(posedge clk); #1; t++;
        end
        check("idle_wait", cmd_ready, 1);
    endtask

    // Monitor: tracks each accepted command and scores it at done/aborted.
    int unsigned cyc = 0, act = 0;
    bit          acc_pend = 0, in_cmd = 0, post_done = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            acc_pend = 0; in_cmd = 0; post_done = 0; cyc = 0; act = 0;
        end else begin
            if (post_done) begin
                check("idle_after_done", {cmd_ready, busy}, 2'b10);
                post_done = 0;
            end
            if (acc_pend) begin
                cyc = 1; act = 0; acc_pend = 0; in_cmd = 1;
            end else if (in_cmd) begin
                cyc++;
            end
            if (in_cmd) begin
                if (sb.size() == 0) begin
                    check("sb_empty", 1, 0);
                    in_cmd = 0;
                end else begin
                    e = sb[0];
                    if (sr_sel != 2'b00) act++;
                    if (cyc <= e.active) begin
                        check("act_sel", sr_sel, e.op);
                        check("act_busy", {busy, cmd_ready}, 2'b10);
                        if (e.op == LOAD) begin
                            check("load_d", sr_d, e.data);
                        end else begin
                            check("shift_rem", remaining, e.n - cyc + 1);
                            if (e.op == SHL)
                                check("fill_shl", {sr_il, sr_ir}, {1'b0, e.rot ? q[31] : e.fill});
                            else
                                check("fill_shr", {sr_il, sr_ir}, {e.rot ? q[0] : e.fill, 1'b0});
                        end
                    end
                    if (done || aborted) begin
                        check("pulse_kind", {done, aborted}, e.is_abort ? 2'b01 : 2'b10);
                        check("pulse_cycle", cyc, e.end_cyc);
                        check("active_cycles", act, e.active);
                        check("reg_value", q, e.q);
                        check("pulse_idle_out", {sr_sel, remaining}, 0);
                        check("pulse_ready_busy", {cmd_ready, busy}, e.is_abort ? 2'b10 : 2'b01);
                        void'(sb.pop_front());
                        in_cmd = 0;
                        if (done) post_done = 1;
                    end else if (cyc > e.end_cyc) begin
                        check("pulse_timeout", cyc, e.end_cyc);
                        void'(sb.pop_front());
                        in_cmd = 0;
                    end
                end
            end else if (done || aborted) begin
                check("unexpected_pulse", {done, aborted}, 2'b00);
            end
            if (cmd_valid && cmd_ready) acc_pend = 1;
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_sel"}, sr_sel, 2'b00);
        check({tag, "_fill"}, {sr_il, sr_ir}, 2'b00);
        check({tag, "_d"}, sr_d, 0);
        check({tag, "_ready"}, cmd_ready, 1);
        check({tag, "_flags"}, {busy, done, aborted}, 3'b000);
        check({tag, "_rem"}, remaining, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] q_before;
        int unsigned r, amode, k;
        logic [1:0]  op;
        logic [5:0]  amt;
        #3;
        check_reset_vals("por");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset mid-SHL amt 5 during cycle 3: two shifts reached the register.
        q_before = ref_q;
        issue(SHL, 6'd5, 1'b1, 32'h0, 1'b0, 0, 0);
        repeat (2) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        sb.delete();
        ref_q = ref_shift(q_before, SHL, 2, 1'b1, 1'b0);
        #1 check_reset_vals("midrst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_release_ready", cmd_ready, 1);
        repeat (3) begin @(posedge clk); #1; end
        check("rst_reg", q, ref_q);

        issue(LOAD, 6'd0, 1'b0, 32'hDEADBEEF, 1'b0, 0, 0);
        wait_idle();
        check("load_q", q, 32'hDEADBEEF);

        issue(LOAD, 6'd0, 1'b0, 32'h0000_00F0, 1'b0, 0, 0);
        issue(SHR, 6'd4, 1'b1, 32'h0, 1'b0, 0, 0);
        wait_idle();
        check("shr4_q", q, 32'hF000_000F);

        issue(SHL, 6'd40, 1'b0, 32'h0, 1'b0, 0, 0);
        wait_idle();
        check("shl40_q", q, 32'h0);
        issue(SHL, 6'd0, 1'b1, 32'h0, 1'b0, 0, 0);

        issue(LOAD, 6'd0, 1'b0, 32'h0000_00FF, 1'b0, 0, 0);
        issue(SHL, 6'd8, 1'b0, 32'h0, 1'b0, 1, 3);
        issue(LOAD, 6'd0, 1'b0, 32'hA5A5_5A5A, 1'b0, 0, 0);
        wait_idle();
        check("abort_then_load_q", q, 32'hA5A5_5A5A);

`ifdef SRWPL_ROTATE_EN
        issue(LOAD, 6'd0, 1'b0, 32'h1234_5678, 1'b0, 0, 0);
        issue(SHR, 6'd8, 1'b0, 32'h0, 1'b1, 0, 0);
        wait_idle();
        check("rot_shr8_q", q, 32'h7812_3456);
`endif

        for (int i = 0; i < 40; i++) begin
            op  = 2'($urandom_range(0, 3));
            amt = ($urandom_range(0, 3) != 0) ? 6'($urandom_range(0, 9))
                                              : 6'($urandom_range(30, 63));
            r = $urandom_range(0, 5);
            amode = (r <= 2) ? 0 : (r == 3) ? 1 : r;
            k = $urandom_range(1, 12);
            issue(op, amt, 1'($urandom), $urandom, 1'($urandom), amode, k);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        wait_idle();
        repeat (3) begin @(posedge clk); #1; end
        check("sb_drained", sb.size(), 0);
        check("final_reg", q, ref_q);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
